// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared PC-source, fetch FSM types and fetch constants
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {PC_INC = 2'b00, PC_BR = 2'b01, PC_JAL = 2'b10} pc_source_t;
  typedef enum logic [1:0] {FS_IDLE, FS_WAIT, FS_DROP} fetch_state_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {pc, instr} buffer with push, pop, flush and full flag
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  always_ff @(posedge clk)
    if (rst || flush) full <= 1'b0;
    else if (push) begin
      full  <= 1'b1;
      pc    <= push_pc;
      instr <= push_instr;
    end else if (pop) full <= 1'b0;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with imem req/ack, redirect squash and skid-buffered decode output
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] jal_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);
  fetch_state_t state;
  logic [31:0] fetch_pc, target, pc_next, skid_pc, skid_instr;
  logic redirect, fire, take, consume, busy, push, pop, skid_full, skid_nx, issue;
  always_comb begin
    redirect = pc_src_i == PC_BR || pc_src_i == PC_JAL;
    target   = (pc_src_i == PC_BR ? br_target_i : jal_target_i) & ~32'h3;
    fire     = imem_req_o && imem_ack_i;
    take     = fire && state == FS_WAIT && !redirect;
    consume  = if_valid_o && !stall_i;
    busy     = state != FS_IDLE && !fire;
    push     = take && if_valid_o && !consume;
    pop      = consume && skid_full && !redirect;
    skid_nx  = !redirect && (push || (skid_full && !pop));
    issue    = !busy && !skid_nx;
    pc_next  = redirect ? target : (fire && state == FS_WAIT) ? fetch_pc + INSTR_BYTES : fetch_pc;
  end
  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_pc   (imem_addr_o),
    .push_instr(imem_rdata_i),
    .full      (skid_full),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state       <= FS_IDLE;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      if_valid_o  <= 1'b0;
      if_pc_o     <= '0;
      if_instr_o  <= NOP_INSTR;
    end else begin
      fetch_pc <= pc_next;
      if (issue) begin
        state       <= FS_WAIT;
        imem_req_o  <= 1'b1;
        imem_addr_o <= pc_next;
      end else if (busy) state <= redirect ? FS_DROP : state;
      else begin
        state      <= FS_IDLE;
        imem_req_o <= 1'b0;
      end
      if (redirect) begin
        if_valid_o <= 1'b0;
        if_instr_o <= NOP_INSTR;
      end else if (!if_valid_o || consume) begin
        if (skid_full) {if_valid_o, if_pc_o, if_instr_o} <= {1'b1, skid_pc, skid_instr};
        else if (take) {if_valid_o, if_pc_o, if_instr_o} <= {1'b1, imem_addr_o, imem_rdata_i};
        else begin
          if_valid_o <= 1'b0;
          if_instr_o <= NOP_INSTR;
        end
      end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, ack = 1'b0;
  logic [1:0] pc_src = 2'b00;
  logic [31:0] br_t = '0, jal_t = '0, rdata;
  logic req, valid;
  logic [31:0] addr, if_pc, if_instr;
  int n_cmp = 0, n_bad = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  always #5 clk = ~clk;
  assign rdata = {16'hC0DE, addr[15:0]};
  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src_i    (pc_src),
    .br_target_i (br_t),
    .jal_target_i(jal_t),
    .stall_i     (stall),
    .imem_req_o  (req),
    .imem_addr_o (addr),
    .imem_ack_i  (ack),
    .imem_rdata_i(rdata),
    .if_valid_o  (valid),
    .if_pc_o     (if_pc),
    .if_instr_o  (if_instr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic ack_v);
    rst = 1'b1;
    pc_src = 2'b00;
    stall = 1'b0;
    ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ack = ack_v;
  endtask
  initial begin
    do_reset(1'b0);
    rst = 1'b1;
    tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP);
    rst = 1'b0;
    ack = 1'b1;
    tick();
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_addr0", addr, 32'h0);
    chk("t1_valid0", 32'(valid), 32'd0);
    tick();
    chk("t1_addr4", addr, 32'h4);
    chk("t1_valid1", 32'(valid), 32'd1);
    chk("t1_pc0", if_pc, 32'h0);
    chk("t1_instr0", if_instr, 32'hC0DE0000);
    pc_src = 2'b11;
    tick();
    chk("t1_addr8", addr, 32'h8);
    chk("t1_pc4", if_pc, 32'h4);
    chk("t1_instr4", if_instr, 32'hC0DE0004);
    pc_src = 2'b00;
    tick();
    chk("t1_addrC", addr, 32'hC);
    chk("t1_pc8", if_pc, 32'h8);
    do_reset(1'b1);
    tick();
    chk("t2_addr0", addr, 32'h0);
    tick();
    chk("t2_pc0", if_pc, 32'h0);
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_req", 32'(req), 32'd1);
      chk("t2_hold_addr", addr, 32'h4);
    end
    chk("t2_gap_valid", 32'(valid), 32'd0);
    ack = 1'b1;
    tick();
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_pc4", if_pc, 32'h4);
    chk("t2_addr8", addr, 32'h8);
    ack = 1'b0;
    tick();
    chk("t2_once", 32'(valid), 32'd0);
    do_reset(1'b1);
    tick();
    tick();
    chk("t3_pc0", if_pc, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_req_low", 32'(req), 32'd0);
      chk("t3_hold_pc", if_pc, 32'h0);
      chk("t3_hold_valid", 32'(valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("t3_pc4", if_pc, 32'h4);
    chk("t3_instr4", if_instr, 32'hC0DE0004);
    chk("t3_req", 32'(req), 32'd1);
    chk("t3_addr8", addr, 32'h8);
    tick();
    chk("t3_pc8", if_pc, 32'h8);
    chk("t3_instr8", if_instr, 32'hC0DE0008);
    tick();
    chk("t3_pcC", if_pc, 32'hC);
    do_reset(1'b1);
    tick();
    tick();
    tick();
    chk("t4_addr8", addr, 32'h8);
    ack = 1'b0;
    tick();
    pc_src = 2'b01;
    br_t = 32'h100;
    tick();
    pc_src = 2'b00;
    chk("t4_drop_addr", addr, 32'h8);
    chk("t4_drop_req", 32'(req), 32'd1);
    tick();
    chk("t4_drop_hold", addr, 32'h8);
    ack = 1'b1;
    tick();
    chk("t4_addr100", addr, 32'h100);
    chk("t4_squash", 32'(valid), 32'd0);
    tick();
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_pc100", if_pc, 32'h100);
    chk("t4_instr100", if_instr, 32'hC0DE0100);
    do_reset(1'b1);
    tick();
    tick();
    pc_src = 2'b10;
    jal_t = 32'h203;
    tick();
    pc_src = 2'b00;
    chk("t5_addr200", addr, 32'h200);
    chk("t5_req", 32'(req), 32'd1);
    chk("t5_valid0", 32'(valid), 32'd0);
    chk("t5_nop", if_instr, NOP);
    tick();
    chk("t5_pc200", if_pc, 32'h200);
    chk("t5_addr204", addr, 32'h204);
    do_reset(1'b0);
    tick();
    tick();
    chk("t6_wait_req", 32'(req), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_req", 32'(req), 32'd0);
    rst = 1'b0;
    ack = 1'b1;
    tick();
    chk("t6_late_ack", 32'(valid), 32'd0);
    chk("t6_restart", addr, 32'h0);
    tick();
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_pc0", if_pc, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
